// File: rtl/button_pkg.sv
// Shared types and constants for the push-button conditioning blocks.
package button_pkg;

    localparam int COUNT_W = 8;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        WAIT_PRESS   = 2'd1,
        HELD         = 2'd2,
        WAIT_RELEASE = 2'd3
    } btn_state_t;

endpackage

// File: rtl/btn_sync.sv
// Two-flop synchroniser for asynchronous board inputs, W lines wide.
module btn_sync #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    // First flop may go metastable; only the second is used downstream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/button_debounce.sv
// Debounces one raw button: clean level, press/release/long-press strobes
// and a wrapping press counter. All outputs are registered.
module button_debounce
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int LONG_CYCLES     = 20
) (
    input  logic               CLK,
    input  logic               RSTN,
    input  logic               SW,
    output logic               PRESSED,
    output logic               PRESS_PULSE,
    output logic               RELEASE_PULSE,
    output logic               LONG_PULSE,
    output logic [COUNT_W-1:0] COUNT
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int HW = $clog2(LONG_CYCLES) + 1;

    localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_CYCLES);
    localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);

    logic       sync;
    btn_state_t state;
    logic [CW-1:0] cnt;
    logic [HW-1:0] hcnt;

    btn_sync #(.W(1)) u_sync (
        .clk   (CLK),
        .rst_n (RSTN),
        .d     (SW),
        .q     (sync)
    );

    // Debounce FSM; the hold counter only advances while settled in HELD,
    // so bounces during a long press pause rather than restart it.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state         <= IDLE;
            cnt           <= '0;
            hcnt          <= '0;
            PRESSED       <= 1'b0;
            PRESS_PULSE   <= 1'b0;
            RELEASE_PULSE <= 1'b0;
            LONG_PULSE    <= 1'b0;
            COUNT         <= '0;
        end else begin
            PRESS_PULSE   <= 1'b0;
            RELEASE_PULSE <= 1'b0;
            LONG_PULSE    <= 1'b0;
            case (state)
                IDLE: begin
                    if (sync) begin
                        state <= WAIT_PRESS;
                        cnt   <= CW'(1);
                    end
                end
                WAIT_PRESS: begin
                    if (!sync) begin
                        state <= IDLE;
                    end else if (cnt == DB_LAST) begin
                        state       <= HELD;
                        PRESSED     <= 1'b1;
                        PRESS_PULSE <= 1'b1;
                        COUNT       <= COUNT + 1'b1;
                        hcnt        <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                HELD: begin
                    if (!sync) begin
                        state <= WAIT_RELEASE;
                        cnt   <= CW'(1);
                    end else if (hcnt != HOLD_MAX) begin
                        hcnt <= hcnt + 1'b1;
                        if (hcnt == HOLD_LAST) LONG_PULSE <= 1'b1;
                    end
                end
                WAIT_RELEASE: begin
                    if (sync) begin
                        state <= HELD;
                        cnt   <= '0;
                    end else if (cnt == DB_LAST) begin
                        state         <= IDLE;
                        PRESSED       <= 1'b0;
                        RELEASE_PULSE <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_button_debounce.sv
// Bench for button_debounce: table segments, hand-written corner sequences
// and randomized bursts, all checked against a run-length reference model.
module tb_button_debounce;

    localparam int D = 4;
    localparam int L = 20;

    logic       CLK = 1'b0;
    logic       RSTN;
    logic       SW;
    logic       PRESSED, PRESS_PULSE, RELEASE_PULSE, LONG_PULSE;
    logic [7:0] COUNT;

    int nvec = 0;
    int nerr = 0;

    button_debounce #(.DEBOUNCE_CYCLES(D), .LONG_CYCLES(L)) dut (
        .CLK           (CLK),
        .RSTN          (RSTN),
        .SW            (SW),
        .PRESSED       (PRESSED),
        .PRESS_PULSE   (PRESS_PULSE),
        .RELEASE_PULSE (RELEASE_PULSE),
        .LONG_PULSE    (LONG_PULSE),
        .COUNT         (COUNT)
    );

    always #5 CLK = ~CLK;

    // Reference model: SW delayed two edges, a level flips after D
    // consecutive samples of the opposite value, hold time counts samples
    // taken while pressed with no pending release run.
    bit       m_s1, m_s2, m_lvl, m_pp, m_rp, m_lp;
    int       m_run, m_hold;
    bit [7:0] m_cnt;

    task automatic model_edge(input bit sw, input bit rstn);
        bit y;
        if (!rstn) begin
            m_s1 = 0; m_s2 = 0; m_lvl = 0; m_pp = 0; m_rp = 0; m_lp = 0;
            m_run = 0; m_hold = 0; m_cnt = 0;
            return;
        end
        m_pp = 0; m_rp = 0; m_lp = 0;
        y = m_s2;
        if (y != m_lvl) begin
            m_run++;
            if (m_run == D) begin
                m_lvl = y;
                m_run = 0;
                if (y) begin
                    m_pp = 1; m_cnt = m_cnt + 8'd1; m_hold = 0;
                end else begin
                    m_rp = 1;
                end
            end
        end else begin
            if (m_lvl && m_run == 0 && m_hold < L) begin
                m_hold++;
                if (m_hold == L) m_lp = 1;
            end
            m_run = 0;
        end
        m_s2 = m_s1;
        m_s1 = sw;
    endtask

    task automatic step(input bit sw, input bit rstn);
        SW = sw;
        RSTN = rstn;
        @(posedge CLK);
        #1;
        model_edge(sw, rstn);
        nvec++;
        if ({PRESSED, PRESS_PULSE, RELEASE_PULSE, LONG_PULSE, COUNT} !==
            {m_lvl, m_pp, m_rp, m_lp, m_cnt}) begin
            nerr++;
            $display("FAIL step%0d: dut pr=%b pp=%b rp=%b lp=%b cnt=%0d, expected pr=%b pp=%b rp=%b lp=%b cnt=%0d",
                     nvec, PRESSED, PRESS_PULSE, RELEASE_PULSE, LONG_PULSE, COUNT,
                     m_lvl, m_pp, m_rp, m_lp, m_cnt);
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        bit sw;
        bit rstn;
        int n;
        bit exp_pressed;
        int exp_count;
    } seg_t;

    seg_t tbl[$];

    initial begin
        int lat, lp_at, npp, nrp, nlp;
        bit seen255;

        SW = 0;
        RSTN = 0;
        // reset with SW toggling, quiet release, bounces, press, bounces while
        // held, long press, release, short press
        tbl = '{
            '{1, 0, 3, 0, 0}, '{0, 0, 2, 0, 0}, '{1, 0, 2, 0, 0},
            '{0, 1, 50, 0, 0},
            '{1, 1, 2, 0, 0}, '{0, 1, 3, 0, 0},
            '{1, 1, 2, 0, 0}, '{0, 1, 3, 0, 0},
            '{1, 1, 2, 0, 0}, '{0, 1, 6, 0, 0},
            '{1, 1, 10, 1, 1},
            '{0, 1, 2, 1, 1}, '{1, 1, 3, 1, 1},
            '{0, 1, 2, 1, 1}, '{1, 1, 3, 1, 1},
            '{0, 1, 2, 1, 1}, '{1, 1, 40, 1, 1},
            '{0, 1, 10, 0, 1},
            '{1, 1, 10, 1, 2}, '{0, 1, 10, 0, 2}
        };
        foreach (tbl[k]) begin
            for (int i = 0; i < tbl[k].n; i++) step(tbl[k].sw, tbl[k].rstn);
            check($sformatf("seg%0d_pressed", k), int'(PRESSED), int'(tbl[k].exp_pressed));
            check($sformatf("seg%0d_count", k), int'(COUNT), tbl[k].exp_count);
        end

        // press latency from the first edge sampling SW=1
        step(0, 0);
        for (int i = 0; i < 5; i++) step(0, 1);
        lat = -1;
        for (int i = 1; i <= 50 && lat < 0; i++) begin
            step(1, 1);
            if (PRESS_PULSE) lat = i;
        end
        check("press_latency", lat, D + 2);

        // long press: one LONG_PULSE exactly L edges after PRESS_PULSE
        lp_at = -1; nlp = 0;
        for (int i = 1; i <= 40; i++) begin
            step(1, 1);
            if (LONG_PULSE) begin
                nlp++;
                if (lp_at < 0) lp_at = i;
            end
        end
        check("long_count", nlp, 1);
        check("long_delay", lp_at, L);
        nrp = 0; lat = -1;
        for (int i = 1; i <= 20; i++) begin
            step(0, 1);
            if (RELEASE_PULSE) begin
                nrp++;
                if (lat < 0) lat = i;
            end
        end
        check("long_release_count", nrp, 1);
        check("release_latency", lat, D + 2);

        // short press: no long strobe
        npp = 0; nrp = 0; nlp = 0;
        for (int i = 0; i < 20; i++) begin
            step(i < 10, 1);
            npp += int'(PRESS_PULSE);
            nrp += int'(RELEASE_PULSE);
            nlp += int'(LONG_PULSE);
        end
        check("short_press", npp, 1);
        check("short_release", nrp, 1);
        check("short_long", nlp, 0);

        // 256 presses wrap the counter back to zero
        step(0, 0);
        seen255 = 0;
        for (int p = 0; p < 256; p++) begin
            for (int i = 0; i < D + 4; i++) step(1, 1);
            if (COUNT == 8'd255) seen255 = 1;
            for (int i = 0; i < D + 4; i++) step(0, 1);
        end
        check("wrap_count", int'(COUNT), 0);
        check("wrap_saw_255", int'(seen255), 1);

        // reset in the middle of WAIT_PRESS cancels the press
        step(0, 0);
        for (int i = 0; i < 3; i++) step(0, 1);
        for (int i = 0; i < 4; i++) step(1, 1);
        step(1, 0);
        npp = 0;
        for (int i = 0; i < 12; i++) begin
            step(0, 1);
            npp += int'(PRESS_PULSE);
        end
        check("midreset_pulse", npp, 0);
        check("midreset_count", int'(COUNT), 0);
        check("midreset_pressed", int'(PRESSED), 0);

        // randomized bursts with occasional resets
        for (int b = 0; b < 300; b++) begin
            bit lvl;
            int len;
            lvl = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 3 * D);
            if ($urandom_range(0, 99) == 0) step(lvl, 0);
            if (lvl && $urandom_range(0, 7) == 0) len = L + 2 * D;
            for (int i = 0; i < len; i++) step(lvl, 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
